// File: rtl/serial_add_seq.sv
// serial_add_seq: sequencer and datapath for a bit-serial adder.
// It feeds one operand bit pair plus the running carry to an external
// full adder each cycle, LSB first. It collects the returned sum bits
// and then offers {cout, sum} through a valid/ready handshake.
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is wide enough to hold WIDTH-1, and it also works for WIDTH=1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] areg_q;
  logic [WIDTH-1:0] breg_q;
  logic [WIDTH-1:0] sreg_q;
  logic             creg_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] areg_d;
  logic [WIDTH-1:0] breg_d;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt_d;
  logic             in_shift;

  assign in_shift = (state_q == SHIFT);

  // Shift values for one SHIFT cycle. Each new sum bit enters at the MSB,
  // so after WIDTH cycles the first (LSB) result bit has moved down to bit 0.
  assign areg_d = areg_q >> 1;
  assign breg_d = breg_q >> 1;
  assign sreg_d = WIDTH'({fa_sum, sreg_q} >> 1);
  assign cnt_d  = cnt_q + CW'(1);

  // Drive the full adder only during SHIFT. Outside SHIFT its inputs are held at 0.
  assign fa_a   = in_shift & areg_q[0];
  assign fa_b   = in_shift & breg_q[0];
  assign fa_cin = in_shift & creg_q;

  // Handshake flags decode directly from the state register, so an async reset clears them at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sreg_q;
  assign cout      = creg_q;

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      sreg_q  <= '0;
      creg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            areg_q  <= a;
            breg_q  <= b;
            creg_q  <= cin;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          areg_q <= areg_d;
          breg_q <= breg_d;
          sreg_q <= sreg_d;
          creg_q <= fa_cout;
          cnt_q  <= cnt_d;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq. A behavioural full adder is wired around
// the sequencer. Directed vectors are checked against hand-computed sums.
module tb_serial_add_seq;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int total;
  int bad;
  int cyc;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // External full adder that the sequencer shares.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vcin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Count rising edges until out_valid shows at #1 after an edge. The wait is bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
  endtask

  // Present one operand and wait through the acceptance edge. Returns the latency to out_valid.
  task automatic do_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vcin, output int n);
    a        = va;
    b        = vb;
    cin      = vcin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
  endtask

  initial begin
    int n;
    int acc;
    int prev_acc;
    logic [WIDTH:0] exp5;
    logic [WIDTH-1:0] exp_fa_a;
    logic [WIDTH-1:0] exp_fa_b;
    logic [WIDTH-1:0] exp_fa_c;

    total = 0; bad = 0; cyc = 0;
    vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
    vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
    vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
    vecs[5] = '{4'd9,  4'd6,  1'b1, 4'd0,  1'b1};
    vecs[6] = '{4'd12, 4'd3,  1'b0, 4'd15, 1'b0};
    vecs[7] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b0};
    vecs[8] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, with the consumer always ready.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, n);
      chk("latency", n, WIDTH);
      chk("sum", sum, vecs[i].exp_sum);
      chk("cout", cout, vecs[i].exp_cout);
      @(posedge clk); #1;
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      $display("vec %0d: %0d+%0d+%0d -> sum=%0d cout=%0d", i, vecs[i].va, vecs[i].vb,
               vecs[i].vcin, sum, cout);
    end

    // Check the bit-serial drive for 1010 + 0110, one cycle at a time.
    exp_fa_a = 4'b1010;
    exp_fa_b = 4'b0110;
    exp_fa_c = 4'b1100;
    a = 4'b1010; b = 4'b0110; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      chk("fa_a", fa_a, exp_fa_a[i]);
      chk("fa_b", fa_b, exp_fa_b[i]);
      chk("fa_cin", fa_cin, exp_fa_c[i]);
      $display("bit %0d: fa_a=%0d fa_b=%0d fa_cin=%0d", i, fa_a, fa_b, fa_cin);
      @(posedge clk); #1;
    end
    chk("serial_valid", out_valid, 1);
    chk("serial_sum", sum, 0);
    chk("serial_cout", cout, 1);
    @(posedge clk); #1;

    // Hold out_ready low for 3 cycles while a new operand is offered.
    out_ready = 1'b0;
    do_op(4'd6, 4'd7, 1'b0, n);
    chk("bp_latency", n, WIDTH);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i % 2 == 0);
      a = 4'(i + 1); b = 4'(i + 2); cin = 1'b1;
      @(posedge clk); #1;
      chk("bp_sum", sum, 13);
      chk("bp_cout", cout, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    a = 4'd2; b = 4'd3; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_new_latency", n, WIDTH);
    chk("bp_new_sum", sum, 6);
    chk("bp_new_cout", cout, 0);
    $display("backpressure: sum=%0d cout=%0d", sum, cout);
    @(posedge clk); #1;

    // Assert reset asynchronously during the third SHIFT cycle.
    a = 4'd15; b = 4'd15; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_active", fa_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_fa", {fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(4'd7, 4'd9, 1'b0, n);
    chk("abort_latency", n, WIDTH);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 1);
    $display("after abort: 7+9 -> sum=%0d cout=%0d", sum, cout);
    @(posedge clk); #1;

    // Back-to-back operation with in_valid and out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      exp5 = (WIDTH + 1)'(a) + (WIDTH + 1)'(b) + (WIDTH + 1)'(cin);
      @(posedge clk); #1;
      acc = cyc;
      if (k > 0) chk("b2b_interval", acc - prev_acc, WIDTH + 2);
      prev_acc = acc;
      wait_valid(n);
      chk("b2b_latency", n, WIDTH);
      chk("b2b_result", {cout, sum}, exp5);
      $display("b2b %0d: %0d+%0d+%0d -> cout=%0d sum=%0d", k, a, b, cin, cout, sum);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Sequencer and datapath that drives the shared one-bit full adder in the serial adder.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Presents one operand bit pair and the registered carry to the full adder each cycle, LSB first.
- Collects the returned sum bits into a result register, then offers sum and carry-out through a valid/ready handshake.

Parameters:
WIDTH, 4, operand and result width in bits; must be at least 1.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset; clears all state immediately.
in_valid  input  1  operand request.
in_ready  output  1  high only in IDLE.
a  input  WIDTH  operand A, sampled on acceptance.
b  input  WIDTH  operand B, sampled on acceptance.
cin  input  1  initial carry, sampled on acceptance.
fa_a  output  1  bit to full adder input a.
fa_b  output  1  bit to full adder input b.
fa_cin  output  1  registered carry to full adder cin.
fa_sum  input  1  sum bit returned by full adder (combinational).
fa_cout  input  1  carry returned by full adder (combinational).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result sum.
cout  output  1  result carry-out.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Internal registers: shift registers areg and breg, result register sreg, carry flop creg, bit counter cnt with width clog2(WIDTH)+1.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - areg, breg, sreg, creg and cnt are cleared to 0.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0.
- Reset asserted mid-operation: the operation is aborted, no out_valid is produced, and the block restarts in IDLE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: areg<=a, breg<=b, creg<=cin, cnt<=0, next state SHIFT.
  - While in_valid=0, all registers hold.
- SHIFT:
  - Combinational drive: fa_a=areg[0], fa_b=breg[0], fa_cin=creg.
  - Each edge: sreg<={fa_sum, sreg[WIDTH-1:1]} (fills MSB-first, so the LSB result ends at bit 0).
  - Each edge: areg and breg shift right by 1 with zero fill; creg<=fa_cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, the bit is processed and the next state is DONE.
  - Exactly WIDTH cycles are spent in SHIFT.
- Outside SHIFT, fa_a, fa_b and fa_cin are forced to 0.
- DONE:
  - out_valid=1, sum=sreg, cout=creg; all are held stable while out_ready=0.
  - On an edge with out_ready=1, next state is IDLE; in_ready is high in the following cycle.
- in_valid is ignored in SHIFT and DONE; no operand is accepted in the cycle a result is consumed.
- Latency: the acceptance edge is E0; out_valid rises after edge E0+WIDTH. Minimum issue interval is WIDTH+2 cycles.
- sum and cout are defined only while out_valid=1. Outside DONE they show internal register contents, and consumers must not sample them.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no truncation of the carry.
- WIDTH=1: exactly one cycle in SHIFT.

Test Plan:
1. WIDTH=4, a=5, b=3, cin=0, out_ready=1 → out_valid exactly 4 cycles after acceptance, sum=8, cout=0, next cycle in_ready=1.
2. a=15, b=1, cin=0 → sum=0, cout=1; a=15, b=15, cin=1 → sum=15, cout=1.
3. a=4'b1010, b=4'b0110, cin=0 → observed per-cycle fa_a=0,1,0,1; fa_b=0,1,1,0; fa_cin=0,0,1,1; then sum=0, cout=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid, toggle in_valid with a new operand → sum and cout stable, in_ready=0, new operand not taken until after out_ready handshake.
5. Drop rst_n asynchronously during the third SHIFT cycle → immediately in_ready=1, out_valid=0, fa_* =0. After release, issue 7+9, cin=0 → sum=0, cout=1, with no residue from the aborted operation.
6. Back-to-back: in_valid and out_ready held at 1 across 20 random operand sets → every result matches a+b+cin, and each acceptance falls WIDTH+2 cycles after the previous one.
